// File: rtl/riscv_defs_pkg.sv
// riscv_defs: constants shared by the fetch unit and control_unit.
package riscv_defs;
    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;
    localparam logic [1:0]  ALIGN_MASK  = 2'b11;
    localparam logic [6:0]  OP_LUI      = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC    = 7'b0010111;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;
    localparam logic [6:0]  OP_JALR     = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OP_LOAD     = 7'b0000011;
    localparam logic [6:0]  OP_STORE    = 7'b0100011;
    localparam logic [6:0]  OP_IMM      = 7'b0010011;
    localparam logic [6:0]  OP_REG      = 7'b0110011;

    function automatic logic is_misaligned(input logic [1:0] a);
        return (a & ALIGN_MASK) != 2'b00;
    endfunction
endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC holder that fetches over req/ready and delivers to decode over valid/ready.
module instruction_fetch_unit
    import riscv_defs::*;
#(
    parameter int                  WORDSIZE         = 64,
    parameter int                  INSTRUCTION_SIZE = 32,
    parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [WORDSIZE-1:0]         imem_addr,
    input  logic [INSTRUCTION_SIZE-1:0] imem_rdata,
    input  logic                        imem_ready,
    output logic [INSTRUCTION_SIZE-1:0] if_instruction,
    output logic [WORDSIZE-1:0]         if_pc,
    output logic                        if_valid,
    input  logic                        id_ready,
    input  logic                        branch_taken,
    input  logic [WORDSIZE-1:0]         branch_target,
    output logic                        if_fault,
    output logic [WORDSIZE-1:0]         if_count
);
    typedef enum logic [1:0] {BOOT, FETCH, DELIVER, FAULT} state_t;

    state_t                      r_state, w_next;
    logic [WORDSIZE-1:0]         r_pc, w_pc, r_if_pc, r_count;
    logic [INSTRUCTION_SIZE-1:0] r_instr;
    logic                        w_cap, w_deliver, w_misalign;

    assign w_misalign = is_misaligned(branch_target[1:0]);
    assign w_deliver  = (r_state == DELIVER) && id_ready;

    // A redirect overrides any same-cycle capture; delivery is still counted separately.
    always_comb begin
        w_next = r_state;
        w_pc   = r_pc;
        w_cap  = 1'b0;
        case (r_state)
            BOOT:    w_next = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    w_next = DELIVER;
                    w_cap  = 1'b1;
                    w_pc   = r_pc + WORDSIZE'(INSTR_BYTES);
                end
            end
            DELIVER: w_next = id_ready ? FETCH : DELIVER;
            default: w_next = FAULT;
        endcase
        if (branch_taken && r_state != FAULT) begin
            w_cap  = 1'b0;
            w_next = w_misalign ? FAULT : FETCH;
            w_pc   = w_misalign ? r_pc : branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_if_pc <= RESET_PC;
            r_instr <= INSTRUCTION_SIZE'(NOP);
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc;
            if (w_cap) begin
                r_instr <= imem_rdata;
                r_if_pc <= r_pc;
            end
            if (w_deliver) r_count <= r_count + WORDSIZE'(1);
        end
    end

    assign imem_req       = (r_state == FETCH);
    assign imem_addr      = r_pc;
    assign if_valid       = (r_state == DELIVER);
    assign if_fault       = (r_state == FAULT);
    assign if_instruction = r_instr;
    assign if_pc          = r_if_pc;
    assign if_count       = r_count;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: per-cycle vector table with an instruction scoreboard, plus fault/reset/wrap sequences.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, if_valid, if_fault, imem_ready, id_ready, branch_taken;
    logic [63:0] imem_addr, if_pc, if_count, branch_target;
    logic [31:0] imem_rdata, if_instruction;
    logic        req2, valid2, fault2;
    logic [63:0] addr2, pc2, count2;
    logic [31:0] rdata2, instr2;

    typedef struct {
        logic        rdy, idr, br;
        logic [63:0] tgt;
        logic        req;
        logic [63:0] addr;
        logic        val;
        logic [63:0] cnt;
        logic        flt;
    } vec_t;
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign rdata2     = mem_word(addr2);

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .if_instruction(if_instruction),
        .if_pc(if_pc), .if_valid(if_valid), .id_ready(id_ready), .branch_taken(branch_taken),
        .branch_target(branch_target), .if_fault(if_fault), .if_count(if_count)
    );

    instruction_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .imem_ready(1'b1), .if_instruction(instr2),
        .if_pc(pc2), .if_valid(valid2), .id_ready(1'b1), .branch_taken(1'b0),
        .branch_target(64'h0), .if_fault(fault2), .if_count(count2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rdy, idr, br, input logic [63:0] tgt,
                               input logic req, input logic [63:0] addr,
                               input logic val, input logic [63:0] cnt, input logic flt);
        vec_t r;
        r.rdy = rdy; r.idr = idr; r.br = br; r.tgt = tgt; r.req = req;
        r.addr = addr; r.val = val; r.cnt = cnt; r.flt = flt;
        return r;
    endfunction

    task automatic check_outputs(input string tag, input logic req, input logic [63:0] addr,
                                 input logic val, input logic [63:0] cnt, input logic flt);
        check({tag, " imem_req"}, 64'(imem_req), 64'(req));
        check({tag, " imem_addr"}, imem_addr, addr);
        check({tag, " if_valid"}, 64'(if_valid), 64'(val));
        check({tag, " if_count"}, if_count, cnt);
        check({tag, " if_fault"}, 64'(if_fault), 64'(flt));
    endtask

    task automatic check_reset(input string tag);
        check_outputs(tag, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        check({tag, " if_instruction"}, 64'(if_instruction), 64'h13);
        check({tag, " if_pc"}, if_pc, 64'h0);
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; id_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
        // c0..c8: back-to-back fetch/deliver from reset
        vecs.push_back(v(1,1,0,0, 0,64'h00,0,0,0));
        vecs.push_back(v(1,1,0,0, 1,64'h00,0,0,0));
        vecs.push_back(v(1,1,0,0, 0,64'h04,1,0,0));
        vecs.push_back(v(1,1,0,0, 1,64'h04,0,1,0));
        vecs.push_back(v(1,1,0,0, 0,64'h08,1,1,0));
        vecs.push_back(v(1,1,0,0, 1,64'h08,0,2,0));
        vecs.push_back(v(1,1,0,0, 0,64'h0C,1,2,0));
        vecs.push_back(v(1,1,0,0, 1,64'h0C,0,3,0));
        vecs.push_back(v(1,1,0,0, 0,64'h10,1,3,0));
        // c9..c12: memory wait at 0x10
        for (int i = 0; i < 3; i++) vecs.push_back(v(0,1,0,0, 1,64'h10,0,4,0));
        vecs.push_back(v(1,1,0,0, 1,64'h10,0,4,0));
        // c13..c18: decode stall then release
        for (int i = 0; i < 5; i++) vecs.push_back(v(1,0,0,0, 0,64'h14,1,4,0));
        vecs.push_back(v(1,1,0,0, 0,64'h14,1,4,0));
        // c19..c24: redirects in FETCH and DELIVER, then a misaligned one
        vecs.push_back(v(1,1,1,64'h100, 1,64'h14,0,5,0));
        vecs.push_back(v(1,1,0,0,       1,64'h100,0,5,0));
        vecs.push_back(v(1,1,1,64'h200, 0,64'h104,1,5,0));
        vecs.push_back(v(1,1,0,0,       1,64'h200,0,6,0));
        vecs.push_back(v(1,1,1,64'h102, 0,64'h204,1,6,0));
        vecs.push_back(v(1,1,0,0,       0,64'h204,0,7,1));

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        foreach (vecs[k]) begin
            check_outputs($sformatf("vec%0d", k), vecs[k].req, vecs[k].addr, vecs[k].val, vecs[k].cnt, vecs[k].flt);
            if (vecs[k].val) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL vec%0d scoreboard: got empty queue expected an entry", k);
                end else begin
                    check($sformatf("vec%0d if_instruction", k), 64'(if_instruction), 64'(sb[0].instr));
                    check($sformatf("vec%0d if_pc", k), if_pc, sb[0].pc);
                    if (vecs[k].idr || vecs[k].br) void'(sb.pop_front());
                end
            end
            imem_ready = vecs[k].rdy; id_ready = vecs[k].idr;
            branch_taken = vecs[k].br; branch_target = vecs[k].tgt;
            if (vecs[k].req && vecs[k].rdy && !vecs[k].br)
                sb.push_back('{mem_word(vecs[k].addr), vecs[k].addr});
            @(negedge clk);
        end
        check("scoreboard drained", 64'(sb.size()), 64'h0);

        // Fault is absorbing even under further aligned redirects
        for (int i = 0; i < 20; i++) begin
            branch_taken = i[0]; branch_target = 64'h300; imem_ready = 1'b1; id_ready = 1'b1;
            @(negedge clk);
            check_outputs($sformatf("fault%0d", i), 1'b0, 64'h204, 1'b0, 64'h7, 1'b1);
        end
        branch_taken = 1'b0;

        rst = 1'b1;
        @(negedge clk);
        check_reset("fault reset");

        // Reset asserted while a fetch is outstanding
        rst = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs("mid fetch", 1'b1, 64'h0, 1'b0, 64'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("mid fetch reset");

        // PC wrap on the alternate-reset instance
        rst = 1'b0;
        @(negedge clk);
        check("wrap req", 64'(req2), 64'h1);
        check("wrap addr0", addr2, 64'hFFFF_FFFF_FFFF_FFFC);
        @(negedge clk);
        check("wrap valid", 64'(valid2), 64'h1);
        check("wrap if_pc", pc2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap instr", 64'(instr2), 64'(mem_word(64'hFFFF_FFFF_FFFF_FFFC)));
        check("wrap pc+4", addr2, 64'h0);
        @(negedge clk);
        check("wrap second fetch", {63'h0, req2} | (addr2 << 1), 64'h1);
        check("wrap count", count2, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
